// File: rtl/forwarding_unit.sv
// ---------------------------------------------------------------------------
// forwarding_unit
//
// Bypass control for the 5-stage pipeline (16 registers, r0 reads as zero).
// The block compares the EX-stage source registers (D/X latch) with the
// destination registers in the X/M and M/W latches. From that it drives the
// ALU operand mux selects and the MEM-stage store-data bypass select. It also
// keeps three saturating hazard-event counters for performance and debug
// visibility.
//
// Ports
//   clk          rising-edge clock (counters only)
//   rst          synchronous active-low reset (counters only)
//   stat_en      counter enable; held low while the pipeline is stalled
//   xm_regwrite  X/M instruction writes the register file
//   mw_regwrite  M/W instruction writes the register file
//   xm_memwrite  X/M instruction is a store
//   xm_rd        X/M destination register
//   xm_rt        X/M store-data source register
//   mw_rd        M/W destination register
//   dx_rs        EX-stage first source register
//   dx_rt        EX-stage second source register
//   forwarda     ALU operand A select: 00 regfile, 01 X/M, 10 M/W
//   forwardb     ALU operand B select: same encoding, built from dx_rt
//   forwardmm    store-data select in MEM: 1 = use M/W writeback value
//   cnt_xm       cycles with any X/M forward
//   cnt_mw       cycles with an M/W forward and no X/M forward
//   cnt_mm       cycles with a MEM-to-MEM forward
//
// The forwarding selects are purely combinational. They do not depend on clk
// or rst, so they stay valid while the clock is idle.
// ---------------------------------------------------------------------------
module forwarding_unit #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stat_en,
  input  logic              xm_regwrite,
  input  logic              mw_regwrite,
  input  logic              xm_memwrite,
  input  logic [REG_AW-1:0] xm_rd,
  input  logic [REG_AW-1:0] xm_rt,
  input  logic [REG_AW-1:0] mw_rd,
  input  logic [REG_AW-1:0] dx_rs,
  input  logic [REG_AW-1:0] dx_rt,
  output logic [1:0]        forwarda,
  output logic [1:0]        forwardb,
  output logic              forwardmm,
  output logic [CNT_W-1:0]  cnt_xm,
  output logic [CNT_W-1:0]  cnt_mw,
  output logic [CNT_W-1:0]  cnt_mm
);

  localparam logic [1:0]       SEL_RF  = 2'b00;
  localparam logic [1:0]       SEL_XM  = 2'b01;
  localparam logic [1:0]       SEL_MW  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // -------------------------------------------------------------------------
  // Match detection. A stage can forward only when it writes a real register:
  // r0 is hardwired to zero, so a "write" to r0 must never be bypassed.
  // -------------------------------------------------------------------------
  logic xm_writes_reg;
  logic mw_writes_reg;
  logic xm_match_rs;
  logic xm_match_rt;
  logic mw_match_rs;
  logic mw_match_rt;
  logic mm_match;

  always_comb begin
    xm_writes_reg = xm_regwrite && (xm_rd != REG_ZERO);
    mw_writes_reg = mw_regwrite && (mw_rd != REG_ZERO);
    xm_match_rs   = xm_writes_reg && (xm_rd == dx_rs);
    xm_match_rt   = xm_writes_reg && (xm_rd == dx_rt);
    mw_match_rs   = mw_writes_reg && (mw_rd == dx_rs);
    mw_match_rt   = mw_writes_reg && (mw_rd == dx_rt);
    // A store in MEM whose data register is being written back by the
    // instruction just ahead of it takes the writeback value directly.
    mm_match      = xm_memwrite && mw_writes_reg && (mw_rd == xm_rt);
  end

  // -------------------------------------------------------------------------
  // Operand selects. X/M wins over M/W because it holds the newer value of
  // the same register. The encoding 11 is never produced.
  // -------------------------------------------------------------------------
  always_comb begin
    forwarda = SEL_RF;
    if (xm_match_rs) begin
      forwarda = SEL_XM;
    end else if (mw_match_rs) begin
      forwarda = SEL_MW;
    end
  end

  always_comb begin
    forwardb = SEL_RF;
    if (xm_match_rt) begin
      forwardb = SEL_XM;
    end else if (mw_match_rt) begin
      forwardb = SEL_MW;
    end
  end

  assign forwardmm = mm_match;

  // -------------------------------------------------------------------------
  // Hazard-event classification. The M/W event counts only the cycles in
  // which no operand came from X/M, so one cycle never lands in both
  // counters.
  // -------------------------------------------------------------------------
  logic ev_xm;
  logic ev_mw;
  logic ev_mm;

  always_comb begin
    ev_xm = (forwarda == SEL_XM) || (forwardb == SEL_XM);
    ev_mw = ((forwarda == SEL_MW) || (forwardb == SEL_MW)) && !ev_xm;
    ev_mm = forwardmm;
  end

  // -------------------------------------------------------------------------
  // Saturating counters. They hold at all-ones instead of wrapping, so a
  // long run still reads as "at least this many" and not as a small number.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_xm_q, cnt_xm_d;
  logic [CNT_W-1:0] cnt_mw_q, cnt_mw_d;
  logic [CNT_W-1:0] cnt_mm_q, cnt_mm_d;

  always_comb begin
    cnt_xm_d = cnt_xm_q;
    cnt_mw_d = cnt_mw_q;
    cnt_mm_d = cnt_mm_q;
    if (stat_en) begin
      if (ev_xm && (cnt_xm_q != CNT_MAX)) begin
        cnt_xm_d = cnt_xm_q + CNT_ONE;
      end
      if (ev_mw && (cnt_mw_q != CNT_MAX)) begin
        cnt_mw_d = cnt_mw_q + CNT_ONE;
      end
      if (ev_mm && (cnt_mm_q != CNT_MAX)) begin
        cnt_mm_d = cnt_mm_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_xm_q <= '0;
      cnt_mw_q <= '0;
      cnt_mm_q <= '0;
    end else begin
      cnt_xm_q <= cnt_xm_d;
      cnt_mw_q <= cnt_mw_d;
      cnt_mm_q <= cnt_mm_d;
    end
  end

  assign cnt_xm = cnt_xm_q;
  assign cnt_mw = cnt_mw_q;
  assign cnt_mm = cnt_mm_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// ---------------------------------------------------------------------------
// tb_forwarding_unit
//
// Drives forwarding_unit with directed scenarios and then with randomized
// pipeline contents. On every cycle the driver pushes the expected outputs
// into a queue. A monitor on the falling edge pops one entry and compares the
// outputs against it. The expected values come from a behavioural model that
// applies the bypass rules directly, using a per-register "who writes it"
// view and integer counters that are clamped at the maximum value.
// ---------------------------------------------------------------------------
module tb_forwarding_unit;

  localparam int REG_AW  = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              stat_en;
  logic              xm_regwrite;
  logic              mw_regwrite;
  logic              xm_memwrite;
  logic [REG_AW-1:0] xm_rd;
  logic [REG_AW-1:0] xm_rt;
  logic [REG_AW-1:0] mw_rd;
  logic [REG_AW-1:0] dx_rs;
  logic [REG_AW-1:0] dx_rt;
  logic [1:0]        forwarda;
  logic [1:0]        forwardb;
  logic              forwardmm;
  logic [CNT_W-1:0]  cnt_xm;
  logic [CNT_W-1:0]  cnt_mw;
  logic [CNT_W-1:0]  cnt_mm;

  forwarding_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .stat_en     (stat_en),
    .xm_regwrite (xm_regwrite),
    .mw_regwrite (mw_regwrite),
    .xm_memwrite (xm_memwrite),
    .xm_rd       (xm_rd),
    .xm_rt       (xm_rt),
    .mw_rd       (mw_rd),
    .dx_rs       (dx_rs),
    .dx_rt       (dx_rt),
    .forwarda    (forwarda),
    .forwardb    (forwardb),
    .forwardmm   (forwardmm),
    .cnt_xm      (cnt_xm),
    .cnt_mw      (cnt_mw),
    .cnt_mm      (cnt_mm)
  );

  // scoreboard
  typedef struct {
    int               tag;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             fmm;
    logic             chk_cnt;
    logic [CNT_W-1:0] cx;
    logic [CNT_W-1:0] cw;
    logic [CNT_W-1:0] cm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  int m_cx;
  int m_cw;
  int m_cm;
  bit m_known = 1'b0;

  // Source of the newest value of register r, as seen from EX:
  // 1 = X/M, 2 = M/W, 0 = register file. r0 always reads from the file.
  function automatic int newest_src(int r, bit xw, int xd, bit mw, int md);
    int owner [16];
    for (int i = 0; i < 16; i++) owner[i] = 0;
    if (mw) owner[md] = 2;   // older writer first ...
    if (xw) owner[xd] = 1;   // ... newer writer overrides it
    owner[0] = 0;
    return owner[r];
  endfunction

  task automatic drive(input bit r, input bit se, input bit xw, input bit mw,
                       input bit xmem, input int xd, input int xt, input int md,
                       input int rs, input int rt, input int tag);
    exp_t e;
    int   sa, sb;
    bit   mm;
    @(posedge clk);
    #1;
    rst = r; stat_en = se; xm_regwrite = xw; mw_regwrite = mw;
    xm_memwrite = xmem;
    xm_rd = REG_AW'(xd); xm_rt = REG_AW'(xt); mw_rd = REG_AW'(md);
    dx_rs = REG_AW'(rs); dx_rt = REG_AW'(rt);
    sa = newest_src(rs, xw, xd, mw, md);
    sb = newest_src(rt, xw, xd, mw, md);
    mm = xmem && mw && (md != 0) && (md == xt);
    e.tag     = tag;
    e.fa      = 2'(sa);
    e.fb      = 2'(sb);
    e.fmm     = mm;
    e.chk_cnt = m_known;
    e.cx      = CNT_W'(m_cx);
    e.cw      = CNT_W'(m_cw);
    e.cm      = CNT_W'(m_cm);
    exp_q.push_back(e);
    // the counters change on the next rising edge
    if (!r) begin
      m_cx = 0; m_cw = 0; m_cm = 0; m_known = 1'b1;
    end else if (se && m_known) begin
      if ((sa == 1 || sb == 1) && m_cx < CNT_MAX) m_cx++;
      if ((sa == 2 || sb == 2) && !(sa == 1 || sb == 1) && m_cw < CNT_MAX) m_cw++;
      if (mm && m_cm < CNT_MAX) m_cm++;
    end
  endtask

  task automatic check(input string name, input int tag, input logic [CNT_W-1:0] got,
                       input logic [CNT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s tag=%0d got=%0h expected=%0h", name, tag, got, exp);
    end
  endtask

  // monitor: the outputs are settled half a cycle after the inputs change
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("forwarda", e.tag, CNT_W'(forwarda), CNT_W'(e.fa));
      check("forwardb", e.tag, CNT_W'(forwardb), CNT_W'(e.fb));
      check("forwardmm", e.tag, CNT_W'(forwardmm), CNT_W'(e.fmm));
      if (e.chk_cnt) begin
        check("cnt_xm", e.tag, cnt_xm, e.cx);
        check("cnt_mw", e.tag, cnt_mw, e.cw);
        check("cnt_mm", e.tag, cnt_mm, e.cm);
      end
    end
  end

  initial begin
    rst = 1'b1; stat_en = 1'b0; xm_regwrite = 1'b0; mw_regwrite = 1'b0;
    xm_memwrite = 1'b0; xm_rd = '0; xm_rt = '0; mw_rd = '0; dx_rs = '0; dx_rt = '0;

    // combinational selects before any reset (counters still unknown)
    drive(1, 0, 1, 1, 1, 1, 1, 2, 1, 2, 1);   // fa=01 fb=10 fmm=0
    drive(1, 0, 1, 1, 1, 2, 1, 1, 1, 2, 2);   // fa=10 fb=01 fmm=1
    drive(1, 0, 1, 1, 0, 3, 0, 3, 3, 3, 3);   // both 01, X/M priority
    drive(1, 0, 0, 1, 0, 3, 0, 3, 3, 3, 4);   // both 10
    drive(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 5);   // r0 never forwarded
    drive(1, 0, 0, 0, 1, 5, 5, 5, 5, 5, 6);   // no regwrite -> nothing
    drive(1, 0, 1, 1, 0, 5, 5, 5, 5, 5, 7);   // no memwrite -> fmm=0

    // counters: reset, 5 counted edges, then 3 held edges
    drive(0, 0, 1, 1, 1, 1, 1, 2, 1, 2, 10);
    for (int i = 0; i < 5; i++) drive(1, 1, 1, 1, 1, 1, 1, 2, 1, 2, 11);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 1, 1, 1, 1, 2, 1, 2, 12);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13);  // cnt_xm=5 cnt_mw=0 cnt_mm=0 seen here

    // randomized pipeline contents, small register range to provoke matches
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), 20);
    end

    // saturation: reset, then 2^CNT_W+2 counted cycles of an X/M forward
    // that is also a MEM-to-MEM forward (rs from X/M, store data from M/W)
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30);
    for (int i = 0; i < (1 << CNT_W) + 2; i++) drive(1, 1, 1, 1, 1, 1, 2, 2, 1, 0, 31);
    drive(1, 1, 1, 1, 1, 1, 2, 2, 1, 0, 32);
    drive(1, 1, 0, 1, 0, 0, 0, 4, 4, 0, 33);  // one M/W-only cycle
    drive(0, 1, 1, 1, 1, 1, 2, 2, 1, 0, 34);  // reset mid-operation
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 35);  // counters cleared

    // let the monitor drain, within a bounded number of cycles
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain got=%0d expected=0 entries left", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Data-forwarding (bypass) control for the 5-stage pipelined CPU (16 registers, r0 hardwired to zero).
- Compares source registers in the EX stage (D/X latch) against destination registers in the X/M and M/W latches.
- Produces the EX-stage ALU operand mux selects and the MEM-stage store-data bypass select.
- Keeps saturating hazard-event counters for performance and debug visibility.

Parameters:
- REG_AW, 4, register-address width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  system clock; rising-edge.
- rst  input  1  synchronous reset, active-low; affects counters only.
- stat_en  input  1  counter enable; tie to 0 when the pipeline is stalled.
- xm_regwrite  input  1  X/M instruction writes the register file.
- mw_regwrite  input  1  M/W instruction writes the register file.
- xm_memwrite  input  1  X/M instruction is a store.
- xm_rd  input  REG_AW  X/M destination register.
- xm_rt  input  REG_AW  X/M store-data source register.
- mw_rd  input  REG_AW  M/W destination register.
- dx_rs  input  REG_AW  EX-stage first source register.
- dx_rt  input  REG_AW  EX-stage second source register.
- forwarda  output  2  ALU operand A select.
- forwardb  output  2  ALU operand B select.
- forwardmm  output  1  store-data select in MEM: 1 = use M/W writeback value.
- cnt_xm  output  CNT_W  cycles with any X/M forward.
- cnt_mw  output  CNT_W  cycles with any M/W-only forward.
- cnt_mm  output  CNT_W  cycles with MEM-to-MEM forward.

Behaviour:
- forwarda, forwardb and forwardmm are purely combinational functions of the current inputs.
  - Zero latency, no clock dependence.
  - Valid even when clk is idle and rst is not asserted.
- Select encoding for forwarda and forwardb:
  - 00: register-file value, no forward.
  - 01: X/M ALU result.
  - 10: M/W writeback value.
  - 11: never produced.
- X/M match on rs: xm_regwrite=1, xm_rd != 0, xm_rd == dx_rs.
- M/W match on rs: mw_regwrite=1, mw_rd != 0, mw_rd == dx_rs.
- forwarda: 01 if X/M match; else 10 if M/W match; else 00.
  - X/M has priority because it holds the newest value.
- forwardb: same rules as forwarda, using dx_rt.
- forwardmm = xm_memwrite & mw_regwrite & (mw_rd != 0) & (mw_rd == xm_rt).
- Register 0 is never forwarded; the destination-equals-0 checks suppress it.
- Both operands may be forwarded in the same cycle, from the same or different stages.
- The forwarding outputs do not depend on xm_memwrite except through forwardmm.
- Counters:
  - Synchronous, active-low reset: on rising clk with rst=0, all counters go to 0. Reset asserted mid-operation clears them on that edge.
  - On rising clk with rst=1 and stat_en=1:
    - cnt_xm increments if forwarda==01 or forwardb==01.
    - cnt_mw increments if (forwarda==10 or forwardb==10) and neither select is 01.
    - cnt_mm increments if forwardmm=1.
  - Counters saturate at all-ones and do not wrap.
  - With stat_en=0, counters hold.
  - Counters are X until the first reset; no initial values are relied on.
- rst has no effect on forwarda, forwardb or forwardmm.

Test Plan:
- dx_rs=1, dx_rt=2, xm_rd=1, mw_rd=2, xm_regwrite=1, mw_regwrite=1, xm_memwrite=1, xm_rt=1 -> forwarda=01, forwardb=10, forwardmm=0.
- Same as above but xm_rd=2, mw_rd=1 -> forwarda=10, forwardb=01, forwardmm=1.
- dx_rs=3, dx_rt=3, xm_rd=3, mw_rd=3, both regwrite=1 -> forwarda=01, forwardb=01 (X/M priority); with xm_regwrite=0 -> both 10.
- xm_rd=0, mw_rd=0, dx_rs=0, dx_rt=0, both regwrite=1, xm_memwrite=1, xm_rt=0 -> forwarda=00, forwardb=00, forwardmm=0.
- All register indices match but both regwrite=0 -> forwarda=00, forwardb=00, forwardmm=0; xm_memwrite=0 alone forces forwardmm=0.
- Counters:
  - Hold rst=0 for one edge -> all counters 0.
  - With scenario 1 held, rst=1 and stat_en=1 for 5 edges -> cnt_xm=5, cnt_mw=0, cnt_mm=0.
  - Drop stat_en for 3 edges -> counters unchanged.
  - Preload by running 2^CNT_W+2 cycles -> cnt_xm saturates at all-ones.
